// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry layout for the reorder buffer, register file and reservation stations.
// ROB_WIDTH_BIT may be overridden by the build; the optional ROB_QUERY_BYPASS_EN lives in reorder_buffer.sv.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 3
`endif

package reorder_buffer_pkg;

  localparam int REG_ID_W = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic                busy;
    logic                ready;
    logic [REG_ID_W-1:0] rd;
    logic [XLEN-1:0]     value;
    logic                is_br;
    logic                is_store;
    logic                pred_taken;
    logic                taken;
    logic [XLEN-1:0]     alt_pc;
  } rob_entry_t;

  function automatic logic is_mispredict(input rob_entry_t e);
    return e.is_br && (e.taken != e.pred_taken);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with rename, CDB write-back, operand query and branch flush.
// Optional: define ROB_QUERY_BYPASS_EN to forward a same-cycle write-back onto the query ports.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_is_br,
  input  logic                     issue_is_store,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic                     rob_full,
  output logic [4:0]               new_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] new_ROB_id,
  input  logic                     wb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
  input  logic [31:0]              wb_val,
  input  logic                     wb_taken,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     commit_store,
  output logic                     clear_flag,
  output logic [31:0]              clear_pc,
  input  logic [ROB_WIDTH_BIT-1:0] q_id1,
  input  logic [ROB_WIDTH_BIT-1:0] q_id2,
  output logic                     q_rdy1,
  output logic                     q_rdy2,
  output logic [31:0]              q_val1,
  output logic [31:0]              q_val2
);

  localparam int SIZE = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0] FULL_CNT = (ROB_WIDTH_BIT+1)'(SIZE);

  rob_entry_t               r_rob [SIZE];
  logic [ROB_WIDTH_BIT-1:0] r_head;
  logic [ROB_WIDTH_BIT-1:0] r_tail;
  logic [ROB_WIDTH_BIT:0]   r_count;
  logic                     r_clear_flag;
  logic [31:0]              r_clear_pc;

  rob_entry_t w_head_e;
  rob_entry_t w_q1_e;
  rob_entry_t w_q2_e;
  logic       w_full;
  logic       w_issue;
  logic       w_commit;
  logic       w_flush;
  logic       w_wb;

  assign w_head_e = r_rob[r_head];
  assign w_q1_e   = r_rob[q_id1];
  assign w_q2_e   = r_rob[q_id2];

  // The flush cycle doubles as a full cycle so the decoder stalls while fetch redirects.
  assign w_full   = (r_count == FULL_CNT) || r_clear_flag;
  assign w_issue  = rst_n_in && rdy_in && issue_valid && !w_full;
  assign w_commit = rdy_in && !r_clear_flag && w_head_e.busy && w_head_e.ready;
  assign w_flush  = w_commit && is_mispredict(w_head_e);
  assign w_wb     = rdy_in && !r_clear_flag && wb_valid && r_rob[wb_rob_id].busy;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < SIZE; i++) r_rob[i] <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_clear_flag <= 1'b0;
      r_clear_pc   <= '0;
    end else if (rdy_in) begin
      r_clear_flag <= w_flush;
      if (w_flush) r_clear_pc <= w_head_e.alt_pc;
      if (w_flush) begin
        for (int i = 0; i < SIZE; i++) r_rob[i].busy <= 1'b0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_wb) begin
          r_rob[wb_rob_id].ready <= 1'b1;
          r_rob[wb_rob_id].value <= wb_val;
          r_rob[wb_rob_id].taken <= wb_taken;
        end
        if (w_commit) begin
          r_rob[r_head].busy <= 1'b0;
          r_head             <= r_head + 1'b1;
        end
        // A non-full tail entry is never busy, so this cannot collide with the write-back above.
        if (w_issue) begin
          r_rob[r_tail] <= '{busy: 1'b1, ready: 1'b0, rd: issue_rd, value: '0,
                             is_br: issue_is_br, is_store: issue_is_store,
                             pred_taken: issue_pred_taken, taken: 1'b0,
                             alt_pc: issue_alt_pc};
          r_tail        <= r_tail + 1'b1;
        end
        r_count <= r_count + {{ROB_WIDTH_BIT{1'b0}}, w_issue}
                           - {{ROB_WIDTH_BIT{1'b0}}, w_commit};
      end
    end
  end

  assign rob_full     = w_full;
  assign new_ROB_id   = r_tail;
  assign new_reg_id   = w_issue ? issue_rd : '0;
  assign write_reg_id = w_commit ? w_head_e.rd : '0;
  assign write_ROB_id = r_head;
  assign write_val    = w_head_e.value;
  assign commit_store = w_commit && w_head_e.is_store;
  assign clear_flag   = r_clear_flag;
  assign clear_pc     = r_clear_pc;

  always_comb begin
    q_rdy1 = w_q1_e.busy && w_q1_e.ready;
    q_val1 = q_rdy1 ? w_q1_e.value : '0;
    q_rdy2 = w_q2_e.busy && w_q2_e.ready;
    q_val2 = q_rdy2 ? w_q2_e.value : '0;
`ifdef ROB_QUERY_BYPASS_EN
    if (rst_n_in && wb_valid && wb_rob_id == q_id1) begin
      q_rdy1 = 1'b1;
      q_val1 = wb_val;
    end
    if (rst_n_in && wb_valid && wb_rob_id == q_id2) begin
      q_rdy2 = 1'b1;
      q_val2 = wb_val;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based in-order commit model.
module tb_reorder_buffer;

  localparam int W = 3;
  localparam int N = 1 << W;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic         rdy_in;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_is_br;
  logic         issue_is_store;
  logic         issue_pred_taken;
  logic [31:0]  issue_alt_pc;
  logic         rob_full;
  logic [4:0]   new_reg_id;
  logic [W-1:0] new_ROB_id;
  logic         wb_valid;
  logic [W-1:0] wb_rob_id;
  logic [31:0]  wb_val;
  logic         wb_taken;
  logic [4:0]   write_reg_id;
  logic [W-1:0] write_ROB_id;
  logic [31:0]  write_val;
  logic         commit_store;
  logic         clear_flag;
  logic [31:0]  clear_pc;
  logic [W-1:0] q_id1, q_id2;
  logic         q_rdy1, q_rdy2;
  logic [31:0]  q_val1, q_val2;

  reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_is_store(issue_is_store), .issue_pred_taken(issue_pred_taken),
    .issue_alt_pc(issue_alt_pc), .rob_full(rob_full), .new_reg_id(new_reg_id),
    .new_ROB_id(new_ROB_id), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id),
    .wb_val(wb_val), .wb_taken(wb_taken), .write_reg_id(write_reg_id),
    .write_ROB_id(write_ROB_id), .write_val(write_val), .commit_store(commit_store),
    .clear_flag(clear_flag), .clear_pc(clear_pc), .q_id1(q_id1), .q_id2(q_id2),
    .q_rdy1(q_rdy1), .q_rdy2(q_rdy2), .q_val1(q_val1), .q_val2(q_val2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic        ready;
    logic [31:0] val;
    logic        br;
    logic        st;
    logic        pred;
    logic        taken;
    logic [31:0] alt;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_tail;
  logic        m_clr;
  logic [31:0] m_clr_pc;
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail   = 0;
    m_clr    = 1'b0;
    m_clr_pc = '0;
  endtask

  task automatic qmodel(input int id, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (mq[i]) if (mq[i].id == id && mq[i].ready) begin
      r = 1'b1;
      v = mq[i].val;
    end
`ifdef ROB_QUERY_BYPASS_EN
    if (wb_valid && int'(wb_rob_id) == id) begin
      r = 1'b1;
      v = wb_val;
    end
`endif
  endtask

  // Check all outputs against the model, clock once, then advance the model.
  task automatic step();
    int          n;
    logic        e_full, e_acc, e_com, e_flush, r;
    logic [31:0] v;
    m_ent_t      hd;
    #2;
    n      = mq.size();
    e_full = (n == N) || m_clr;
    e_acc  = issue_valid && !e_full && rdy_in;
    e_com  = 1'b0;
    if (n > 0) begin
      hd    = mq[0];
      e_com = rdy_in && !m_clr && hd.ready;
    end
    e_flush = e_com && hd.br && (hd.taken != hd.pred);
    chk("rob_full", 32'(rob_full), 32'(e_full));
    chk("new_ROB_id", 32'(new_ROB_id), 32'(m_tail));
    chk("new_reg_id", 32'(new_reg_id), e_acc ? 32'(issue_rd) : 32'd0);
    chk("write_reg_id", 32'(write_reg_id), e_com ? 32'(hd.rd) : 32'd0);
    chk("commit_store", 32'(commit_store), 32'(e_com && hd.st));
    if (e_com) begin
      chk("write_ROB_id", 32'(write_ROB_id), 32'(hd.id));
      chk("write_val", write_val, hd.val);
    end
    chk("clear_flag", 32'(clear_flag), 32'(m_clr));
    if (m_clr) chk("clear_pc", clear_pc, m_clr_pc);
    qmodel(int'(q_id1), r, v);
    chk("q_rdy1", 32'(q_rdy1), 32'(r));
    chk("q_val1", q_val1, v);
    qmodel(int'(q_id2), r, v);
    chk("q_rdy2", 32'(q_rdy2), 32'(r));
    chk("q_val2", q_val2, v);
    @(posedge clk_in);
    if (rdy_in) begin
      if (wb_valid && !m_clr)
        foreach (mq[i]) if (mq[i].id == int'(wb_rob_id)) begin
          mq[i].ready = 1'b1;
          mq[i].val   = wb_val;
          mq[i].taken = wb_taken;
        end
      m_clr = e_flush;
      if (e_flush) begin
        m_clr_pc = hd.alt;
        mq.delete();
        m_tail = 0;
      end else begin
        if (e_com) void'(mq.pop_front());
        if (e_acc) begin
          mq.push_back('{id: m_tail, rd: issue_rd, ready: 1'b0, val: '0, br: issue_is_br,
                         st: issue_is_store, pred: issue_pred_taken, taken: 1'b0,
                         alt: issue_alt_pc});
          m_tail = (m_tail + 1) % N;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_br = 1'b0;
    issue_is_store = 1'b0; issue_pred_taken = 1'b0; issue_alt_pc = '0;
    wb_valid = 1'b0; wb_rob_id = '0; wb_val = '0; wb_taken = 1'b0;
    q_id1 = '0; q_id2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic br, input logic st,
                       input logic pred, input logic [31:0] alt);
    idle();
    issue_valid = 1'b1; issue_rd = rd; issue_is_br = br;
    issue_is_store = st; issue_pred_taken = pred; issue_alt_pc = alt;
  endtask

  task automatic wb(input int id, input logic [31:0] val, input logic tk);
    idle();
    wb_valid = 1'b1; wb_rob_id = W'(id); wb_val = val; wb_taken = tk;
  endtask

  initial begin
    idle();
    rst_n_in = 1'b0;
    model_reset();
    #2;
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_wreg", 32'(write_reg_id), 32'd0);
    chk("rst_cstore", 32'(commit_store), 32'd0);
    chk("rst_clear", 32'(clear_flag), 32'd0);
    do_reset();

    // Rename then commit one entry.
    issue(5'd5, 0, 0, 0, '0);
    #1;
    chk("r30_nreg", 32'(new_reg_id), 32'd5);
    chk("r30_nrob", 32'(new_ROB_id), 32'd0);
    step();
    wb(0, 32'h1234, 0);
    step();
    idle();
    #1;
    chk("r30_wreg", 32'(write_reg_id), 32'd5);
    chk("r30_wval", write_val, 32'h1234);
    step();

    // Fill to full; the extra issue is rejected.
    do_reset();
    for (int i = 0; i < N; i++) begin
      issue(5'(i + 1), 0, (i == 1), 0, '0);
      step();
    end
    issue(5'd9, 0, 0, 0, '0);
    #1;
    chk("r31_full", 32'(rob_full), 32'd1);
    chk("r31_nreg", 32'(new_reg_id), 32'd0);
    step();
    chk("r31_tail", 32'(new_ROB_id), 32'd0);

    // Out-of-order write-back, in-order commit.
    wb(1, 32'hB1, 0);
    step();
    wb(0, 32'hB0, 0);
    #1;
    chk("r32_nocommit", 32'(write_reg_id), 32'd0);
    step();
    wb(2, 32'hB2, 0);
    #1;
    chk("r32_c0", 32'(write_ROB_id), 32'd0);
    chk("r32_c0_rd", 32'(write_reg_id), 32'd1);
    step();
    idle();
    #1;
    chk("r32_c1", 32'(write_ROB_id), 32'd1);
    chk("r32_store", 32'(commit_store), 32'd1);
    step();

    // Asynchronous reset drops a ready head mid-operation.
    idle();
    rst_n_in = 1'b0;
    model_reset();
    #1;
    chk("r35_wreg", 32'(write_reg_id), 32'd0);
    chk("r35_full", 32'(rob_full), 32'd0);
    chk("r35_tail", 32'(new_ROB_id), 32'd0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    step();

    // Mispredicted branch at head flushes.
    issue(5'd3, 1, 0, 1, 32'h100);
    step();
    wb(0, 32'h55, 0);
    step();
    issue(5'd4, 0, 0, 0, '0);
    #1;
    chk("r33_wreg", 32'(write_reg_id), 32'd3);
    step();
    issue(5'd6, 0, 0, 0, '0);
    #1;
    chk("r33_flag", 32'(clear_flag), 32'd1);
    chk("r33_pc", clear_pc, 32'h100);
    chk("r33_full", 32'(rob_full), 32'd1);
    chk("r33_tail", 32'(new_ROB_id), 32'd0);
    chk("r33_nreg", 32'(new_reg_id), 32'd0);
    step();
    idle();
    #1;
    chk("r33_flag_off", 32'(clear_flag), 32'd0);
    step();

    // Query visibility around write-back.
    for (int i = 0; i < 3; i++) begin
      issue(5'(i + 1), 0, 0, 0, '0);
      step();
    end
    wb(2, 32'd7, 0);
    q_id1 = 3'd2;
    #1;
`ifdef ROB_QUERY_BYPASS_EN
    chk("r34_rdy_byp", 32'(q_rdy1), 32'd1);
    chk("r34_val_byp", q_val1, 32'd7);
`else
    chk("r34_rdy", 32'(q_rdy1), 32'd0);
`endif
    step();
    idle();
    q_id1 = 3'd2;
    #1;
    chk("r34_rdy_late", 32'(q_rdy1), 32'd1);
    chk("r34_val_late", q_val1, 32'd7);
    step();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy_in           = ($urandom_range(0, 9) != 0);
      issue_valid      = ($urandom_range(0, 99) < 60);
      issue_rd         = 5'($urandom);
      issue_is_br      = ($urandom_range(0, 9) == 0);
      issue_is_store   = ($urandom_range(0, 3) == 0);
      issue_pred_taken = 1'($urandom);
      issue_alt_pc     = $urandom;
      wb_valid         = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        wb_rob_id = W'(mq[$urandom_range(0, mq.size() - 1)].id);
      else
        wb_rob_id = W'($urandom);
      wb_val   = $urandom;
      wb_taken = 1'($urandom);
      q_id1    = W'($urandom);
      q_id2    = W'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
